// File: rtl/fb_wbstage_pkg.sv
// Shared widths, types and constants for the Firebird write-back stage.
package fb_wbstage_pkg;

    localparam int FB_32BITS = 32;
    localparam int FB_REGNUM = 32;
    localparam int FB_SB_W   = 2;
    localparam int FB_AW     = $clog2(FB_REGNUM);

    typedef logic [FB_32BITS-1:0] word_t;
    typedef logic [FB_AW-1:0]     reg_idx_t;
    typedef logic [FB_SB_W-1:0]   sb_cnt_t;

    localparam reg_idx_t FB_X0  = '0;
    localparam sb_cnt_t  SB_MAX = '1;

endpackage

// File: rtl/fb_regfile.sv
// 32x32 integer register file with x0 hardwired to zero
// and same-cycle write-to-read bypass on both read ports.
module fb_regfile
    import fb_wbstage_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     we_i,
    input  reg_idx_t waddr_i,
    input  word_t    wdata_i,
    input  reg_idx_t raddr_a_i,
    input  reg_idx_t raddr_b_i,
    output word_t    rdata_a_o,
    output word_t    rdata_b_o
);

    word_t regs_q [FB_REGNUM];
    logic  wr_en;

    assign wr_en = we_i && (waddr_i != FB_X0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FB_REGNUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass is gated by reset so reads are zero while held in reset.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != FB_X0) begin
            if (rst_ni && wr_en && waddr_i == raddr_a_i) begin
                rdata_a_o = wdata_i;
            end else begin
                rdata_a_o = regs_q[raddr_a_i];
            end
        end
        if (raddr_b_i != FB_X0) begin
            if (rst_ni && wr_en && waddr_i == raddr_b_i) begin
                rdata_b_o = wdata_i;
            end else begin
                rdata_b_o = regs_q[raddr_b_i];
            end
        end
    end

endmodule

// File: rtl/fb_wbstage.sv
// Firebird write-back stage: result mux, register file commit,
// bypassed decode reads and pending-load scoreboard.
module fb_wbstage
    import fb_wbstage_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wb_valid,
    input  logic     wb_mem_to_reg,
    input  logic     wb_reg_write,
    input  word_t    wb_memory_data,
    input  word_t    wb_alu_res,
    input  reg_idx_t wb_register_rd,
    output word_t    wb_data,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    output word_t    id_rs1_data,
    output word_t    id_rs2_data,
    input  logic     ex_load_issue,
    input  reg_idx_t ex_load_rd,
    output logic     id_load_hazard,
    output logic     sb_err
);

    logic    we;
    logic    inc;
    logic    dec;
    sb_cnt_t cnt_q [FB_REGNUM];
    sb_cnt_t cnt_d [FB_REGNUM];
    logic    err_q;
    logic    err_d;
    logic    hz;

    assign wb_data = wb_mem_to_reg ? wb_memory_data : wb_alu_res;
    assign we      = wb_valid && wb_reg_write && (wb_register_rd != FB_X0);
    assign inc     = ex_load_issue && (ex_load_rd != FB_X0);
    assign dec     = we && wb_mem_to_reg;

    fb_regfile u_rf (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_i      (we),
        .waddr_i   (wb_register_rd),
        .wdata_i   (wb_data),
        .raddr_a_i (id_rs1),
        .raddr_b_i (id_rs2),
        .rdata_a_o (id_rs1_data),
        .rdata_b_o (id_rs2_data)
    );

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < FB_REGNUM; i++) begin
            logic inc_i;
            logic dec_i;
            inc_i    = inc && (ex_load_rd == reg_idx_t'(i));
            dec_i    = dec && (wb_register_rd == reg_idx_t'(i));
            cnt_d[i] = cnt_q[i];
            if (i == 0) begin
                cnt_d[i] = '0;
            end else if (inc_i && !dec_i) begin
                if (cnt_q[i] == SB_MAX) err_d = 1'b1;
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_i && !inc_i) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FB_REGNUM; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < FB_REGNUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    // A load committing this cycle is served by the bypass, so it
    // no longer counts against its reader.
    always_comb begin
        hz = 1'b0;
        for (int n = 0; n < 2; n++) begin
            reg_idx_t rs;
            sb_cnt_t  c;
            rs = (n == 0) ? id_rs1 : id_rs2;
            c  = cnt_q[rs];
            if (dec && wb_register_rd == rs && c != '0) begin
                c = c - 1'b1;
            end
            if (rs != FB_X0 && c != '0) begin
                hz = 1'b1;
            end
        end
    end

    assign id_load_hazard = rst_n && hz;
    assign sb_err         = err_q;

endmodule

// File: tb/tb_fb_wbstage.sv
// Directed bench for fb_wbstage: commit, bypass, scoreboard, reset.
module tb_fb_wbstage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic [31:0] wb_memory_data;
    logic [31:0] wb_alu_res;
    logic [4:0]  wb_register_rd;
    logic [31:0] wb_data;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        ex_load_issue;
    logic [4:0]  ex_load_rd;
    logic        id_load_hazard;
    logic        sb_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_wbstage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_reg_write   (wb_reg_write),
        .wb_memory_data (wb_memory_data),
        .wb_alu_res     (wb_alu_res),
        .wb_register_rd (wb_register_rd),
        .wb_data        (wb_data),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .ex_load_issue  (ex_load_issue),
        .ex_load_rd     (ex_load_rd),
        .id_load_hazard (id_load_hazard),
        .sb_err         (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_valid       = 1'b0;
        wb_mem_to_reg  = 1'b0;
        wb_reg_write   = 1'b0;
        wb_memory_data = '0;
        wb_alu_res     = '0;
        wb_register_rd = '0;
        ex_load_issue  = 1'b0;
        ex_load_rd     = '0;
    endtask

    // Start a new cycle: inputs change at negedge, checks follow at +1.
    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    task automatic commit(input logic [4:0] rd, input logic load,
                          input logic [31:0] d);
        wb_valid       = 1'b1;
        wb_reg_write   = 1'b1;
        wb_mem_to_reg  = load;
        wb_register_rd = rd;
        if (load) wb_memory_data = d;
        else wb_alu_res = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        ex_load_issue = 1'b1;
        ex_load_rd    = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        id_rs1 = 5'd5;
        id_rs2 = 5'd7;
        commit(5'd5, 1'b0, 32'h1234_5678);
        #2;
        chk("rst_rs1_gated", id_rs1_data, 32'h0);
        chk("rst_rs2", id_rs2_data, 32'h0);
        chk("rst_hz", {31'b0, id_load_hazard}, 32'h0);
        chk("rst_err", {31'b0, sb_err}, 32'h0);
        chk("rst_wbdata", wb_data, 32'h1234_5678);

        cyc();
        rst_n = 1'b1;
        commit(5'd5, 1'b0, 32'h1234_5678);
        #1;
        chk("alu_bypass_x5", id_rs1_data, 32'h1234_5678);

        cyc();
        id_rs1 = 5'd0;
        id_rs2 = 5'd5;
        commit(5'd0, 1'b0, 32'hFFFF_FFFF);
        #1;
        chk("x5_regs", id_rs2_data, 32'h1234_5678);
        chk("x0_bypass", id_rs1_data, 32'h0);

        cyc();
        id_rs1 = 5'd8;
        wb_mem_to_reg  = 1'b1;
        wb_memory_data = 32'h55AA_55AA;
        wb_alu_res     = 32'h0000_0011;
        wb_valid       = 1'b1;
        wb_register_rd = 5'd8;
        #1;
        chk("wbdata_mem_noreg", wb_data, 32'h55AA_55AA);
        chk("nowrite_byp", id_rs1_data, 32'h0);

        cyc();
        id_rs1 = 5'd0;
        id_rs2 = 5'd8;
        wb_alu_res = 32'hCAFE_0000;
        #1;
        chk("x0_after", id_rs1_data, 32'h0);
        chk("x8_unwritten", id_rs2_data, 32'h0);
        chk("wbdata_alu_invalid", wb_data, 32'hCAFE_0000);

        cyc();
        id_rs1 = 5'd5;
        id_rs2 = 5'd7;
        commit(5'd7, 1'b0, 32'hDEAD_BEEF);
        #1;
        chk("x7_bypass", id_rs2_data, 32'hDEAD_BEEF);

        cyc();
        #1;
        chk("x7_regs", id_rs2_data, 32'hDEAD_BEEF);
        chk("x5_keep", id_rs1_data, 32'h1234_5678);

        cyc();
        id_rs1 = 5'd3;
        id_rs2 = 5'd0;
        issue(5'd3);
        #1;
        chk("lu_issue_cyc", {31'b0, id_load_hazard}, 32'h0);
        cyc();
        #1;
        chk("lu_hz1", {31'b0, id_load_hazard}, 32'h1);
        cyc();
        #1;
        chk("lu_hz2", {31'b0, id_load_hazard}, 32'h1);
        cyc();
        commit(5'd3, 1'b1, 32'hA5A5_0001);
        #1;
        chk("lu_commit_hz", {31'b0, id_load_hazard}, 32'h0);
        chk("lu_commit_data", id_rs1_data, 32'hA5A5_0001);
        cyc();
        #1;
        chk("lu_after_hz", {31'b0, id_load_hazard}, 32'h0);
        chk("lu_after_data", id_rs1_data, 32'hA5A5_0001);

        cyc();
        id_rs1 = 5'd0;
        id_rs2 = 5'd9;
        issue(5'd9);
        cyc();
        issue(5'd9);
        #1;
        chk("x9_cnt1_hz", {31'b0, id_load_hazard}, 32'h1);
        cyc();
        commit(5'd9, 1'b1, 32'h0000_0091);
        #1;
        chk("x9_first_commit", {31'b0, id_load_hazard}, 32'h1);
        cyc();
        #1;
        chk("x9_cnt1", {31'b0, id_load_hazard}, 32'h1);
        cyc();
        issue(5'd9);
        commit(5'd9, 1'b1, 32'h0000_0092);
        #1;
        chk("x9_incdec_hz", {31'b0, id_load_hazard}, 32'h0);
        cyc();
        #1;
        chk("x9_incdec_keep", {31'b0, id_load_hazard}, 32'h1);
        chk("x9_data", id_rs2_data, 32'h0000_0092);
        cyc();
        commit(5'd9, 1'b1, 32'h0000_0093);
        #1;
        chk("x9_last_commit", {31'b0, id_load_hazard}, 32'h0);
        cyc();
        #1;
        chk("x9_drained", {31'b0, id_load_hazard}, 32'h0);
        chk("x9_no_err", {31'b0, sb_err}, 32'h0);

        id_rs2 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            cyc();
            issue(5'd4);
        end
        cyc();
        #1;
        chk("x4_cnt3_noerr", {31'b0, sb_err}, 32'h0);
        chk("x4_hz", {31'b0, id_load_hazard}, 32'h1);
        issue(5'd4);
        cyc();
        #1;
        chk("x4_overflow_err", {31'b0, sb_err}, 32'h1);
        cyc();
        #1;
        chk("x4_err_sticky", {31'b0, sb_err}, 32'h1);

        id_rs1 = 5'd3;
        id_rs2 = 5'd0;
        issue(5'd3);
        cyc();
        issue(5'd3);
        cyc();
        #1;
        chk("x3_cnt2_hz", {31'b0, id_load_hazard}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_hz_drop", {31'b0, id_load_hazard}, 32'h0);
        chk("async_err_clr", {31'b0, sb_err}, 32'h0);
        chk("async_x3_zero", id_rs1_data, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        id_rs2 = 5'd5;
        #1;
        chk("post_rst_x3", id_rs1_data, 32'h0);
        chk("post_rst_hz", {31'b0, id_load_hazard}, 32'h0);
        chk("post_rst_x5", id_rs2_data, 32'h0);

        cyc();
        id_rs1 = 5'd6;
        id_rs2 = 5'd0;
        commit(5'd6, 1'b1, 32'h0606_0606);
        #1;
        chk("uf_commit_noerr", {31'b0, sb_err}, 32'h0);
        cyc();
        #1;
        chk("uf_err", {31'b0, sb_err}, 32'h1);
        chk("uf_cnt0_hz", {31'b0, id_load_hazard}, 32'h0);
        chk("uf_data", id_rs1_data, 32'h0606_0606);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
